// File: rtl/lobo_pkg.sv
// Shared definitions for the hybrid Booth / leading-one multiplier: default geometry,
// Booth digit encoding and the leading-one helpers used by the low-part approximation.
package lobo_pkg;

    localparam int W_DEF    = 16;
    localparam int TH_DEF   = 12;
    localparam int TS_DEF   = 8;
    localparam int TAGW_DEF = 4;
    localparam int NDIG     = (W_DEF - TH_DEF) / 2;
    localparam int PW       = 2 * W_DEF;

    typedef struct packed {
        logic one;
        logic two;
        logic neg;
    } booth_t;

    // Radix-4 digit from {x[2i+1], x[2i], x[2i-1]}; 111 encodes zero, not -0.
    function automatic booth_t booth_enc(input logic [2:0] b);
        booth_t d;
        d.one = b[1] ^ b[0];
        d.two = (b == 3'b011) || (b == 3'b100);
        d.neg = b[2] & ~(b[1] & b[0]);
        return d;
    endfunction

    function automatic logic [5:0] lod_pos(input logic [63:0] v);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) p = 6'(i);
        end
        return p;
    endfunction

    // Values below 2^ts collapse onto k = 0 so the residue carries their magnitude.
    function automatic logic [5:0] quant_k(input logic [63:0] v, input int ts);
        logic [5:0] p;
        p = lod_pos(v);
        return (int'(p) >= ts) ? p : 6'd0;
    endfunction

endpackage

// File: rtl/lobo_log_pp.sv
// Low-part approximation: one's-complement magnitudes, quantised leading-one detect,
// residue shift and sign handling, producing the single extra partial-product row L.
module lobo_log_pp
    import lobo_pkg::*;
#(
    parameter int W  = 16,
    parameter int TH = 12,
    parameter int TS = 8
) (
    input  logic [TH-1:0]  i_xl,
    input  logic [W-1:0]   i_y,
    output logic [2*W-1:0] o_l
);
    localparam int PWL = 2 * W;

    logic           w_sx;
    logic           w_sy;
    logic [TH-1:0]  w_ax;
    logic [TH-1:0]  w_r;
    logic [W-1:0]   w_ay;
    logic [5:0]     w_k;
    logic [5:0]     w_j;
    logic [PWL-1:0] w_m;
    logic [PWL-1:0] w_res;

    assign w_sx  = i_xl[TH-1];
    assign w_sy  = i_y[W-1];
    assign w_ax  = i_xl ^ {TH{w_sx}};
    assign w_ay  = i_y ^ {W{w_sy}};
    assign w_k   = quant_k(64'(w_ax), TS);
    assign w_j   = lod_pos(64'(w_ay[W-1:W-4]));
    assign w_r   = w_ax - (TH'(1) << w_k);
    assign w_m   = PWL'(w_ay) << w_k;
    // Residue is scaled by the leading one of y's top nibble only.
    assign w_res = (w_ay[W-1:W-4] == 4'd0) ? '0 : (PWL'(w_r) << (6'(W - 4) + w_j));

    always_comb begin
        o_l = '0;
        if ((w_ax != '0) && (w_ay != '0)) begin
            if (w_sx ^ w_sy) o_l = ~w_m + ~w_res;
            else             o_l = w_m + w_res;
        end
    end

endmodule

// File: rtl/lobo_mul_pipe.sv
// Three-stage valid/ready signed multiplier: exact radix-4 Booth, or Booth on the high
// digits plus a log-style approximation of the low TH multiplier bits, selected per transaction.
module lobo_mul_pipe
    import lobo_pkg::*;
#(
    parameter int W    = PW / 2,
    parameter int TH   = PW / 2 - 2 * NDIG,
    parameter int TS   = TS_DEF,
    parameter int TAGW = TAGW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_x,
    input  logic [W-1:0]    in_y,
    input  logic            in_mode,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W-1:0]  out_p,
    output logic [TAGW-1:0] out_tag,
    output logic            out_mode
);
    localparam int P2W = 2 * W;
    localparam int NB  = W / 2;
    localparam int NLO = TH / 2;
    localparam int NR  = NB + 1;

    genvar gi;

    logic            r_s1_valid, r_s2_valid, r_s3_valid;
    logic            w_ld1, w_ld2, w_ld3;
    booth_t          w_dig [NB];
    booth_t          r_s1_dig [NB];
    logic [TH-1:0]   r_s1_xl;
    logic [W-1:0]    r_s1_y;
    logic            r_s1_mode, r_s2_mode, r_s3_mode;
    logic [TAGW-1:0] r_s1_tag, r_s2_tag, r_s3_tag;
    logic [P2W-1:0]  r_s2_s, r_s2_c, r_s3_p;
    logic [P2W-1:0]  w_yext;
    logic [P2W-1:0]  w_l;
    logic [P2W-1:0]  w_row [NR];
    logic [P2W-1:0]  w_cs_s [NR-1];
    logic [P2W-1:0]  w_cs_c [NR-1];

    assign w_ld3    = !r_s3_valid || out_ready;
    assign w_ld2    = !r_s2_valid || w_ld3;
    assign w_ld1    = !r_s1_valid || w_ld2;
    assign in_ready = w_ld1;

    for (gi = 0; gi < NB; gi++) begin : g_enc
        if (gi == 0) begin : g_first
            assign w_dig[gi] = booth_enc({in_x[1], in_x[0], 1'b0});
        end else begin : g_rest
            assign w_dig[gi] = booth_enc({in_x[2*gi+1], in_x[2*gi], in_x[2*gi-1]});
        end
    end

    lobo_log_pp #(.W(W), .TH(TH), .TS(TS)) u_log_pp (
        .i_xl (r_s1_xl),
        .i_y  (r_s1_y),
        .o_l  (w_l)
    );

    assign w_yext = {{W{r_s1_y[W-1]}}, r_s1_y};

    for (gi = 0; gi < NB; gi++) begin : g_row
        logic [P2W-1:0] w_mag;
        logic [P2W-1:0] w_pp;
        assign w_mag = r_s1_dig[gi].two ? (w_yext << 1) : (r_s1_dig[gi].one ? w_yext : '0);
        assign w_pp  = r_s1_dig[gi].neg ? (~w_mag + P2W'(1)) : w_mag;
        // Approximate mode replaces these low digits by the log-part row.
        if (gi < NLO) begin : g_lo
            assign w_row[gi] = r_s1_mode ? '0 : (w_pp << (2 * gi));
        end else begin : g_hi
            assign w_row[gi] = w_pp << (2 * gi);
        end
    end
    assign w_row[NB] = r_s1_mode ? w_l : '0;

    assign w_cs_s[0] = w_row[0];
    assign w_cs_c[0] = w_row[1];
    for (gi = 2; gi < NR; gi++) begin : g_csa
        assign w_cs_s[gi-1] = w_cs_s[gi-2] ^ w_cs_c[gi-2] ^ w_row[gi];
        assign w_cs_c[gi-1] = ((w_cs_s[gi-2] & w_cs_c[gi-2]) | (w_cs_s[gi-2] & w_row[gi]) |
                               (w_cs_c[gi-2] & w_row[gi])) << 1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            for (int i = 0; i < NB; i++) r_s1_dig[i] <= '0;
            r_s1_xl    <= '0;
            r_s1_y     <= '0;
            r_s1_mode  <= 1'b0;
            r_s1_tag   <= '0;
            r_s2_s     <= '0;
            r_s2_c     <= '0;
            r_s2_mode  <= 1'b0;
            r_s2_tag   <= '0;
            r_s3_p     <= '0;
            r_s3_mode  <= 1'b0;
            r_s3_tag   <= '0;
        end else begin
            if (w_ld1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_dig  <= w_dig;
                    r_s1_xl   <= in_x[TH-1:0];
                    r_s1_y    <= in_y;
                    r_s1_mode <= in_mode;
                    r_s1_tag  <= in_tag;
                end
            end
            if (w_ld2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_s    <= w_cs_s[NR-2];
                    r_s2_c    <= w_cs_c[NR-2];
                    r_s2_mode <= r_s1_mode;
                    r_s2_tag  <= r_s1_tag;
                end
            end
            if (w_ld3) begin
                r_s3_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_s3_p    <= r_s2_s + r_s2_c;
                    r_s3_mode <= r_s2_mode;
                    r_s3_tag  <= r_s2_tag;
                end
            end
        end
    end

    assign out_valid = r_s3_valid;
    assign out_p     = r_s3_p;
    assign out_tag   = r_s3_tag;
    assign out_mode  = r_s3_mode;

endmodule

// File: tb/tb_lobo_mul_pipe.sv
// Bench for lobo_mul_pipe: directed products, backpressure, mid-stream reset and random
// regression of a 16-bit and a 24-bit instance against an arithmetic reference model.
module tb_lobo_mul_pipe;

    typedef struct {
        longint p;
        int     tag;
        bit     mode;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rst24;
    logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [15:0] in_x, in_y;
    logic [3:0]  in_tag, out_tag;
    logic [31:0] out_p;
    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_mode;
    logic [23:0] b_in_x, b_in_y;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [47:0] b_out_p;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q16[$];
    exp_t q24[$];
    exp_t e16, e24;
    int   n_out16 = 0;
    bit   saw_stall = 0;
    bit   done24 = 0;

    always #5 clk = ~clk;

    lobo_mul_pipe #(.W(16), .TH(12), .TS(8), .TAGW(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag), .out_mode(out_mode)
    );

    lobo_mul_pipe #(.W(24), .TH(16), .TS(10), .TAGW(4)) u_dut24 (
        .clk(clk), .rst(rst24), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x),
        .in_y(b_in_y), .in_mode(b_in_mode), .in_tag(b_in_tag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_p(b_out_p), .out_tag(b_out_tag), .out_mode(b_out_mode)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic longint sext(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        v = v & m;
        return v[w-1] ? v - (longint'(1) << w) : v;
    endfunction

    function automatic int msb(input longint v);
        int p;
        p = -1;
        for (int i = 0; i < 64; i++) if (v[i]) p = i;
        return p;
    endfunction

    // x = H*2^th + xl, so the exact Booth part is (x - xl)*y; L follows the log-part rules.
    function automatic longint model(input int w, input int th, input int ts,
                                     input longint x, input longint y, input bit mode);
        longint mask, xs, ys, xl, xls, ax, ay, r, m, rr, l;
        int     k, top, j;
        bit     sx, sy;
        mask = (longint'(1) << (2 * w)) - 1;
        xs   = sext(x, w);
        ys   = sext(y, w);
        if (!mode) return (xs * ys) & mask;
        xl  = x & ((longint'(1) << th) - 1);
        xls = sext(xl, th);
        sx  = xl[th-1];
        sy  = ys < 0;
        ax  = sx ? (~xl & ((longint'(1) << th) - 1)) : xl;
        ay  = sy ? (~y & ((longint'(1) << w) - 1)) : (y & ((longint'(1) << w) - 1));
        k   = (msb(ax) >= ts) ? msb(ax) : 0;
        r   = ax - (longint'(1) << k);
        top = int'(ay >> (w - 4));
        j   = msb(longint'(top));
        rr  = (top == 0) ? 0 : (r << (w - 4 + j));
        m   = ay << k;
        if (ax == 0 || ay == 0) l = 0;
        else if (sx ^ sy)       l = (~m & mask) + (~rr & mask);
        else                    l = m + rr;
        return ((xs - xls) * ys + l) & mask;
    endfunction

    // Scoreboard for the 16-bit instance, sampled mid-cycle.
    logic        held16 = 0;
    logic [31:0] hold_p;
    logic [3:0]  hold_tag;
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            q16.delete();
            held16 = 0;
        end else begin
            if (held16) begin
                chk("hold_p", longint'(out_p), longint'(hold_p));
                chk("hold_tag", longint'(out_tag), longint'(hold_tag));
            end
            if (out_valid && out_ready) begin
                n_out16++;
                if (q16.size() == 0) chk("extra_out16", 1, 0);
                else begin
                    e16 = q16.pop_front();
                    chk("p16", longint'(out_p), e16.p);
                    chk("tag16", longint'(out_tag), longint'(e16.tag));
                    chk("mode16", longint'(out_mode), longint'(e16.mode));
                end
            end
            held16   = out_valid && !out_ready;
            hold_p   = out_p;
            hold_tag = out_tag;
            if (in_valid && !in_ready) saw_stall = 1;
            if (in_valid && in_ready) begin
                e16.p    = model(16, 12, 8, longint'(in_x), longint'(in_y), in_mode);
                e16.tag  = int'(in_tag);
                e16.mode = in_mode;
                q16.push_back(e16);
            end
        end
    end

    always begin
        @(negedge clk);
        #3;
        if (rst24) q24.delete();
        else begin
            if (b_out_valid && b_out_ready) begin
                if (q24.size() == 0) chk("extra_out24", 1, 0);
                else begin
                    e24 = q24.pop_front();
                    chk("p24", longint'(b_out_p), e24.p);
                    chk("tag24", longint'(b_out_tag), longint'(e24.tag));
                    chk("mode24", longint'(b_out_mode), longint'(e24.mode));
                end
            end
            if (b_in_valid && b_in_ready) begin
                e24.p    = model(24, 16, 10, longint'(b_in_x), longint'(b_in_y), b_in_mode);
                e24.tag  = int'(b_in_tag);
                e24.mode = b_in_mode;
                q24.push_back(e24);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic m,
                          input logic [3:0] t);
        bit ok;
        in_valid = 1; in_x = x; in_y = y; in_mode = m; in_tag = t;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            #4;
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!ok) chk("send16_timeout", 0, 1);
    endtask

    task automatic send24(input logic [23:0] x, input logic [23:0] y, input logic m,
                          input logic [3:0] t);
        bit ok;
        b_in_valid = 1; b_in_x = x; b_in_y = y; b_in_mode = m; b_in_tag = t;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            #4;
            ok = b_in_ready;
            @(posedge clk);
            #1;
        end
        b_in_valid = 0;
        if (!ok) chk("send24_timeout", 0, 1);
    endtask

    task automatic single(input logic [15:0] x, input logic [15:0] y, input logic m,
                          input logic [3:0] t, input longint exp_p, input string name);
        int lat;
        send16(x, y, m, t);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_lat"}, lat, 3);
        chk({name, "_p"}, longint'(out_p), exp_p);
        chk({name, "_tag"}, longint'(out_tag), longint'(t));
    endtask

    function automatic logic [23:0] rnd_op(input int w);
        logic [23:0] v;
        v = 24'($urandom);
        case ($urandom_range(0, 3))
            0: v = v & ((24'd1 << $urandom_range(1, w - 1)) - 24'd1);
            1: v = ~(v & ((24'd1 << $urandom_range(1, w - 1)) - 24'd1));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        rst = 1; in_valid = 0; in_x = '0; in_y = '0; in_mode = 0; in_tag = '0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_p", longint'(out_p), 0);
        chk("rst_out_tag", longint'(out_tag), 0);
        chk("rst_out_mode", longint'(out_mode), 0);
        rst = 0;
        @(posedge clk);
        #1;

        single(16'hFFFD, 16'd7, 1'b0, 4'd5, 64'hFFFFFFEB, "exact_neg");
        single(16'h0100, 16'h0003, 1'b1, 4'd1, 64'h300, "approx_pow2");
        single(16'd5, 16'd1000, 1'b1, 4'd2, 64'd1000, "approx_quant");
        single(16'hFFFF, 16'd2, 1'b1, 4'd3, 64'd0, "approx_zero");
        @(posedge clk);
        #1;

        // Backpressure: out_ready low for cycles 4..8 of the burst
        begin
            int base_out;
            base_out  = n_out16;
            saw_stall = 0;
            fork
                for (int t = 0; t < 6; t++)
                    send16(16'($urandom), 16'($urandom), 1'($urandom), 4'(t));
                begin
                    for (int c = 1; c <= 12; c++) begin
                        out_ready = !(c >= 4 && c <= 8);
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1;
                end
            join
            repeat (8) @(posedge clk);
            #1;
            chk("bp_stall_seen", saw_stall, 1);
            chk("bp_delivered", n_out16 - base_out, 6);
            chk("bp_queue_empty", q16.size(), 0);
        end

        // Reset with three transactions in flight
        begin
            int stale;
            for (int t = 0; t < 3; t++) send16(16'($urandom), 16'($urandom), 1'($urandom), 4'(8 + t));
            #2;
            rst = 1;
            #1;
            chk("rst_mid_out_valid", longint'(out_valid), 0);
            chk("rst_mid_out_p", longint'(out_p), 0);
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 0;
            stale = 0;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (out_valid) stale++;
            end
            chk("rst_no_stale", stale, 0);
            single(16'h1234, 16'hF00D, 1'b1, 4'd7,
                   model(16, 12, 8, 64'h1234, 64'hF00D, 1'b1), "post_rst");
        end
        @(posedge clk);
        #1;

        // Random regression, both modes, random gaps and backpressure
        begin
            bit done16;
            done16 = 0;
            fork
                begin
                    for (int i = 0; i < 300; i++) begin
                        if ($urandom_range(0, 4) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        send16(rnd_op(16)[15:0], rnd_op(16)[15:0], 1'($urandom), 4'($urandom));
                    end
                    done16 = 1;
                end
                begin
                    while (!done16) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                        @(posedge clk);
                        #1;
                    end
                    out_ready = 1;
                end
            join
            repeat (8) @(posedge clk);
            #1;
            chk("rand16_queue_empty", q16.size(), 0);
        end

        for (int c = 0; c < 20000 && !done24; c++) @(posedge clk);
        if (!done24) chk("tb24_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        bit d;
        rst24 = 1; b_in_valid = 0; b_in_x = '0; b_in_y = '0; b_in_mode = 0; b_in_tag = '0;
        b_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst24 = 0;
        @(posedge clk);
        #1;
        d = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) send24(rnd_op(24), rnd_op(24), 1'($urandom), 4'($urandom));
                d = 1;
            end
            begin
                while (!d) begin
                    b_out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                b_out_ready = 1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        chk("rand24_queue_empty", q24.size(), 0);
        done24 = 1;
    end

endmodule
